// File: rtl/core_reset_sequencer_pkg.sv
// Shared types and constants for the core reset sequencer and its cause encoder.
package core_reset_pkg;

  typedef enum logic [1:0] {
    ST_HOLD   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RUN    = 2'd2
  } state_e;

  localparam int unsigned CAUSE_W   = 3;
  localparam int unsigned SEQ_W     = 16;
  localparam logic [2:0]  CAUSE_PLL = 3'd7;

  localparam int unsigned REQ_BRIDGE = 0;
  localparam int unsigned REQ_DIP    = 1;
  localparam int unsigned REQ_SVC    = 2;
  localparam int unsigned REQ_EXT    = 3;

endpackage

// File: rtl/core_reset_sequencer_if.sv
// Request/status bundle between the reset sequencer (slave) and the bridge/PLL side (master).
interface core_reset_sequencer_if #(
  parameter int unsigned NUM_REQ = 4
) ();
  logic [NUM_REQ-1:0] req;
  logic               pll_locked;
  logic               core_reset;
  logic               mem_hold;
  logic               busy;
  logic               done;
  logic [1:0]         state;
  logic [NUM_REQ-1:0] last_cause;
  logic [2:0]         first_cause;
  logic [15:0]        seq_count;

  modport slave (
    input  req, pll_locked,
    output core_reset, mem_hold, busy, done, state, last_cause, first_cause, seq_count
  );

  modport master (
    output req, pll_locked,
    input  core_reset, mem_hold, busy, done, state, last_cause, first_cause, seq_count
  );
endinterface

// File: rtl/core_reset_sequencer_cause_enc.sv
// Priority encoder: index of the lowest set request bit, CAUSE_PLL when none is set.
module reset_cause_encoder
  import core_reset_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]  i_req,
  output logic [CAUSE_W-1:0]  o_idx
);

  // Scan high to low so the lowest set bit is the last to write.
  always_comb begin
    o_idx = CAUSE_PLL;
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      if (i_req[i]) o_idx = CAUSE_W'(i);
    end
  end

endmodule

// File: rtl/core_reset_sequencer.sv
// Core reset sequencer: merges reset requests and PLL loss into a HOLD -> SETTLE -> RUN
// sequence and reports cause/status for bridge readback.
module core_reset_sequencer
  import core_reset_pkg::*;
#(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned HOLD_CYCLES   = 8000,
  parameter int unsigned SETTLE_CYCLES = 256
) (
  input  logic                   clk_74a,
  input  logic                   reset,
  core_reset_sequencer_if.slave  bus
);

  localparam int unsigned MAX_CYC = (HOLD_CYCLES > SETTLE_CYCLES) ? HOLD_CYCLES : SETTLE_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] HOLD_RELOAD   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_RELOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [SEQ_W-1:0] SEQ_MAX       = {SEQ_W{1'b1}};

  logic [CAUSE_W-1:0] w_enc;
  logic               w_any_req;
  logic               w_cnt_zero;

  state_e             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_core_reset;
  logic               r_mem_hold;
  logic               r_busy;
  logic               r_done;
  logic [NUM_REQ-1:0] r_last_cause;
  logic [CAUSE_W-1:0] r_first_cause;
  logic [SEQ_W-1:0]   r_seq_count;

  reset_cause_encoder #(.NUM_REQ(NUM_REQ)) u_cause_enc (
    .i_req (bus.req),
    .o_idx (w_enc)
  );

  assign w_any_req  = |bus.req;
  assign w_cnt_zero = (r_cnt == '0);

  always_ff @(posedge clk_74a) begin
    if (reset) begin
      r_state       <= ST_HOLD;
      r_cnt         <= HOLD_RELOAD;
      r_core_reset  <= 1'b1;
      r_mem_hold    <= 1'b1;
      r_busy        <= 1'b1;
      r_done        <= 1'b0;
      r_last_cause  <= '0;
      r_first_cause <= CAUSE_PLL;
      r_seq_count   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_HOLD: begin
          r_last_cause <= r_last_cause | bus.req;
          if (w_any_req || !bus.pll_locked) begin
            r_cnt <= HOLD_RELOAD;
          end else if (w_cnt_zero) begin
            r_state    <= ST_SETTLE;
            r_cnt      <= SETTLE_RELOAD;
            r_mem_hold <= 1'b0;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        ST_SETTLE: begin
          r_last_cause <= r_last_cause | bus.req;
          if (w_any_req) begin
            r_state    <= ST_HOLD;
            r_cnt      <= HOLD_RELOAD;
            r_mem_hold <= 1'b1;
          end else if (!bus.pll_locked) begin
            r_cnt <= SETTLE_RELOAD;
          end else if (w_cnt_zero) begin
            r_state      <= ST_RUN;
            r_core_reset <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b1;
            if (r_seq_count != SEQ_MAX) r_seq_count <= r_seq_count + SEQ_W'(1);
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        ST_RUN: begin
          // A request outranks a simultaneous PLL loss when recording the cause.
          if (w_any_req || !bus.pll_locked) begin
            r_state      <= ST_HOLD;
            r_cnt        <= HOLD_RELOAD;
            r_core_reset <= 1'b1;
            r_mem_hold   <= 1'b1;
            r_busy       <= 1'b1;
            r_last_cause  <= w_any_req ? bus.req : '0;
            r_first_cause <= w_any_req ? w_enc : CAUSE_PLL;
          end
        end
        default: begin
          r_state      <= ST_HOLD;
          r_cnt        <= HOLD_RELOAD;
          r_core_reset <= 1'b1;
          r_mem_hold   <= 1'b1;
          r_busy       <= 1'b1;
        end
      endcase
    end
  end

  assign bus.core_reset  = r_core_reset;
  assign bus.mem_hold    = r_mem_hold;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.state       = r_state;
  assign bus.last_cause  = r_last_cause;
  assign bus.first_cause = r_first_cause;
  assign bus.seq_count   = r_seq_count;

endmodule

// File: tb/tb_core_reset_sequencer.sv
// Directed bench for core_reset_sequencer with HOLD=8, SETTLE=4 and a phase/remaining-cycles model.
module tb_core_reset_sequencer;
  import core_reset_pkg::*;

  localparam int unsigned NR   = 4;
  localparam int          HOLD = 8;
  localparam int          SETL = 4;

  logic clk_74a = 1'b0;
  logic reset   = 1'b1;

  core_reset_sequencer_if #(.NUM_REQ(NR)) bus ();

  core_reset_sequencer #(
    .NUM_REQ       (NR),
    .HOLD_CYCLES   (HOLD),
    .SETTLE_CYCLES (SETL)
  ) dut (
    .clk_74a (clk_74a),
    .reset   (reset),
    .bus     (bus)
  );

  always #5 clk_74a = ~clk_74a;

  // Model: phase 0=HOLD 1=SETTLE 2=RUN, m_left = cycles still to spend in the phase.
  int          m_phase = 0;
  int          m_left  = HOLD;
  logic [NR-1:0] m_last = '0;
  int          m_first = 7;
  int          m_seq   = 0;
  bit          m_done  = 1'b0;
  bit          m_valid = 1'b0;
  int          preset_req  = 0;
  int          preset_seen = 0;

  always @(posedge clk_74a) begin
    if (reset) begin
      m_phase = 0; m_left = HOLD; m_last = '0; m_first = 7; m_seq = 0; m_done = 1'b0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      if (preset_req != preset_seen) begin
        preset_seen = preset_req;
        m_seq = 65535;
      end
      m_done = 1'b0;
      if (m_phase == 0) begin
        m_last = m_last | bus.req;
        if (bus.req != 0 || !bus.pll_locked) m_left = HOLD;
        else if (m_left == 1) begin m_phase = 1; m_left = SETL; end
        else m_left = m_left - 1;
      end else if (m_phase == 1) begin
        m_last = m_last | bus.req;
        if (bus.req != 0) begin m_phase = 0; m_left = HOLD; end
        else if (!bus.pll_locked) m_left = SETL;
        else if (m_left == 1) begin
          m_phase = 2; m_done = 1'b1;
          if (m_seq < 65535) m_seq = m_seq + 1;
        end else m_left = m_left - 1;
      end else begin
        if (bus.req != 0) begin
          m_phase = 0; m_left = HOLD; m_last = bus.req;
          m_first = -1;
          for (int i = 0; i < int'(NR); i++) begin
            if (bus.req[i] && m_first < 0) m_first = i;
          end
        end else if (!bus.pll_locked) begin
          m_phase = 0; m_left = HOLD; m_last = '0; m_first = 7;
        end
      end
    end
  end

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic          s_core_reset, s_mem_hold, s_busy, s_done;
  logic [1:0]    s_state;
  logic [NR-1:0] s_last;
  logic [2:0]    s_first;
  logic [15:0]   s_seq;

  function automatic void chk(string name, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", name, cyc, act, exp);
    end
  endfunction

  task automatic sample_and_compare();
    s_core_reset = bus.core_reset; s_mem_hold = bus.mem_hold; s_busy = bus.busy;
    s_done = bus.done; s_state = bus.state; s_last = bus.last_cause;
    s_first = bus.first_cause; s_seq = bus.seq_count;
    if (m_valid) begin
      chk("core_reset", int'(s_core_reset), int'(m_phase != 2));
      chk("mem_hold",   int'(s_mem_hold),   int'(m_phase == 0));
      chk("busy",       int'(s_busy),       int'(m_phase != 2));
      chk("done",       int'(s_done),       int'(m_done));
      chk("state",      int'(s_state),      m_phase);
      chk("last_cause", int'(s_last),       int'(m_last));
      chk("first_cause",int'(s_first),      m_first);
      chk("seq_count",  int'(s_seq),        m_seq);
    end
  endtask

  // One cycle: compare away from the edge, then return just after the next rising edge.
  task automatic tick();
    @(negedge clk_74a);
    sample_and_compare();
    @(posedge clk_74a);
    #1;
    cyc++;
  endtask

  task automatic tick_preset();
    @(negedge clk_74a);
    sample_and_compare();
    #1;
    force dut.r_seq_count = 16'hFFFF;
    preset_req++;
    #1;
    release dut.r_seq_count;
    @(posedge clk_74a);
    #1;
    cyc++;
  endtask

  task automatic pulse(input logic [NR-1:0] v);
    bus.req = v;
    tick();
    bus.req = '0;
  endtask

  // sel: 0 counts core_reset high, 1 mem_hold high, 2 state==SETTLE; stops at first miss.
  task automatic count_while(input int sel, output int n, output int dones);
    bit hit;
    n = 0; dones = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      dones += int'(s_done);
      hit = (sel == 0) ? s_core_reset : (sel == 1) ? s_mem_hold : (s_state == 2'd1);
      if (hit) n++;
      else break;
    end
  endtask

  task automatic wait_state(input int st, input string name);
    for (int k = 0; k < 40; k++) begin
      tick();
      if (int'(s_state) == st) break;
    end
    chk(name, int'(s_state), st);
  endtask

  logic [NR-1:0] rv;
  int n, d;

  initial begin
    bus.req = '0;
    bus.pll_locked = 1'b1;

    // Power-on
    repeat (3) tick();
    chk("rst_state", int'(s_state), 0);
    chk("rst_core_reset", int'(s_core_reset), 1);
    chk("rst_first", int'(s_first), 7);
    chk("rst_seq", int'(s_seq), 0);
    reset = 1'b0;
    count_while(0, n, d);
    chk("poweron_len", n, 12);
    chk("poweron_done_cnt", d, 1);
    chk("poweron_seq", int'(s_seq), 1);
    chk("poweron_first", int'(s_first), 7);

    // Multi-bit request in RUN
    pulse(4'b0110);
    tick();
    chk("req_core_reset", int'(s_core_reset), 1);
    chk("req_last", int'(s_last), 6);
    chk("req_first", int'(s_first), 1);
    count_while(0, n, d);
    chk("req_len", n + 1, 12);
    chk("req_seq", int'(s_seq), 2);

    // PLL-started sequence, extended by req[0] in HOLD and req[3] in SETTLE
    bus.pll_locked = 1'b0; tick(); bus.pll_locked = 1'b1;
    repeat (4) tick();
    rv = '0; rv[REQ_BRIDGE] = 1'b1;
    pulse(rv);
    count_while(1, n, d);
    chk("ext_hold_len", n, 8);
    rv = '0; rv[REQ_EXT] = 1'b1;
    pulse(rv);
    count_while(0, n, d);
    chk("ext_total_len", n, 12);
    chk("ext_last", int'(s_last), 9);
    chk("ext_first", int'(s_first), 7);
    chk("ext_seq", int'(s_seq), 3);

    // PLL unlocked for 10 cycles in SETTLE
    rv = '0; rv[REQ_DIP] = 1'b1;
    pulse(rv);
    wait_state(1, "reach_settle");
    bus.pll_locked = 1'b0;
    repeat (10) tick();
    chk("unlock_state", int'(s_state), 1);
    bus.pll_locked = 1'b1;
    count_while(2, n, d);
    chk("relock_len", n, 4);
    chk("relock_done_cnt", d, 1);
    chk("relock_seq", int'(s_seq), 4);

    // PLL loss in RUN
    bus.pll_locked = 1'b0; tick(); bus.pll_locked = 1'b1;
    tick();
    chk("pll_first", int'(s_first), 7);
    chk("pll_last", int'(s_last), 0);
    chk("pll_mem_hold", int'(s_mem_hold), 1);
    count_while(1, n, d);
    chk("pll_hold_len", n + 1, 8);
    wait_state(2, "pll_run");
    chk("pll_seq", int'(s_seq), 5);

    // Saturation, then reset mid-SETTLE
    tick_preset();
    rv = '0; rv[REQ_SVC] = 1'b1;
    pulse(rv);
    wait_state(2, "sat_run");
    chk("sat_seq", int'(s_seq), 65535);
    rv = '0; rv[REQ_EXT] = 1'b1;
    pulse(rv);
    wait_state(1, "rst_settle");
    reset = 1'b1; tick(); reset = 1'b0;
    tick();
    chk("mid_rst_state", int'(s_state), 0);
    chk("mid_rst_core", int'(s_core_reset), 1);
    chk("mid_rst_mem", int'(s_mem_hold), 1);
    chk("mid_rst_last", int'(s_last), 0);
    chk("mid_rst_first", int'(s_first), 7);
    chk("mid_rst_seq", int'(s_seq), 0);
    count_while(0, n, d);
    chk("mid_rst_len", n + 1, 12);
    chk("mid_rst_seq_after", int'(s_seq), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
